stream_demux1to2: RTL and testbench
===================================

Name: stream_demux1to2

Overview:
- Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2-to-1 source multiplexers in the UART datapath.
- Accepts one valid/ready input stream and steers each beat to output 0 or output 1 according to a per-beat select.
- Each output has its own one-entry holding register, so a stalled sink never blocks beats bound for the other sink.
- Sits between the bus-side write path and the UART TX / loopback consumers.

Parameters:
- DATA_WIDTH, 8, width of every data beat.
- CNT_WIDTH, 16, width of the per-output transfer counters; used only when DEMUX_XFER_CNT_EN is defined.

Ports:
- clock  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when high together with in_valid.
- in_sel  input  1  destination of the current beat: 0 = out0, 1 = out1; qualified by in_valid.
- in_data  input  DATA_WIDTH  input beat payload.
- out0_valid  output  1  out0 slot holds a beat.
- out0_ready  input  1  sink 0 consumes the beat when high together with out0_valid.
- out0_data  output  DATA_WIDTH  out0 slot payload.
- out1_valid, out1_ready, out1_data  same as the out0 ports, for sink 1.
- cnt0, cnt1  output  CNT_WIDTH each  beats delivered on out0 / out1; present only with DEMUX_XFER_CNT_EN.

Behaviour:
- Reset (async assert, sync-style deassert by the system):
  - out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - Counters = 0.
  - in_ready is combinational, so it follows the rules below once reset releases.
- Slot states, per output, two states:
  - EMPTY: valid = 0.
  - FULL: valid = 1.
- Slot transitions:
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on pop without write.
  - FULL -> FULL on pop with write (reload) or on no pop.
- Definitions:
  - pop_k = outk_valid & outk_ready.
  - space_k = ~outk_valid | pop_k.
- in_ready:
  - in_ready = space_0 when in_sel = 0, space_1 when in_sel = 1.
  - in_ready depends combinationally on in_sel and outk_ready. No path from in_valid to in_ready.
- Write: when in_valid & in_ready, in_data is captured into slot in_sel on the clock edge. outk_valid rises the next cycle (latency 1).
- Unselected slot: unaffected by the write; it may pop independently in the same cycle.
- Full slot, no pop: holds data and valid stable. The source must hold in_valid, in_sel and in_data stable until accepted. in_sel changing while in_valid is high and in_ready is low is a protocol violation; the block makes no guarantee in that case.
- Simultaneous pop and write on the same slot: the new beat replaces the old one and valid stays 1. This gives full throughput of 1 beat/cycle per output.
- Both slots full with no pops: in_ready = 0 for either in_sel.
- Ordering: preserved per output. No ordering guarantee between out0 and out1.
- outk_data is driven directly from a register. No combinational path from in_data to outputs.
- Reset asserted mid-operation: buffered beats are discarded, valids drop immediately (asynchronously), counters clear. A beat handshaken in the same cycle reset asserts is lost.

Optional Feature:
- Macro: DEMUX_XFER_CNT_EN.
- Defined:
  - Ports cnt0/cnt1 exist.
  - cntk increments by 1 on every pop_k cycle.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Reset to 0.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_demux_pkg:
  - Localparams SEL_OUT0 = 1'b0 and SEL_OUT1 = 1'b1.
  - No typedefs beyond these.
- One sub-module: demux_slot.
  - Contents: one-entry holding register with wr_en/wr_data, valid/ready/data out, space out, and the optional counter.
  - Instantiated twice.
  - The top level contains only in_ready selection and write-enable steering.

Test Plan:
- Reset then single beat, in_sel = 0, in_data = 0xA5, out0_ready = 1:
  - out0_valid high with 0xA5 exactly 1 cycle after the handshake.
  - out1_valid stays 0.
- Back-to-back stream to out1, data 0x01..0x10, out1_ready held 1:
  - in_ready stays 1 throughout.
  - 16 beats arrive in order at 1 beat/cycle.
  - cnt1 = 16 with DEMUX_XFER_CNT_EN.
- Isolation: out0_ready = 0, send 0x11 to out0, then 0x22 to out1:
  - 0x11 held on out0.
  - 0x22 delivered on out1 the cycle after its handshake.
  - in_ready = 0 for any further in_sel = 0 beat until out0_ready = 1.
- Reload: out0 full with 0x33; same cycle out0_ready = 1 and input 0x44 to out0:
  - Next cycle out0_valid = 1, out0_data = 0x44.
- Mid-operation reset: both slots full (0x55, 0x66), reset pulsed:
  - Both valids drop asynchronously, data = 0, counters = 0.
  - First post-reset beat is delivered normally.
- Counter wrap with CNT_WIDTH = 4: 17 pops on out0 -> cnt0 reads 1.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake.
// DEMUX_XFER_CNT_EN adds a wrapping count of delivered beats.
module demux_slot #(
  parameter int unsigned DataWidth = 8
`ifdef DEMUX_XFER_CNT_EN
  ,
  parameter int unsigned CntWidth  = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 space_o
`ifdef DEMUX_XFER_CNT_EN
  ,
  output logic [CntWidth-1:0]  cnt_o
`endif
);

  logic                 valid_d, valid_q;
  logic [DataWidth-1:0] data_d, data_q;
  logic                 pop;

  assign pop     = valid_q & ready_i;
  assign space_o = ~valid_q | pop;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // A write always wins over a pop, so pop+write reloads the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      data_d  = wr_data_i;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef DEMUX_XFER_CNT_EN
  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/stream_demux1to2.sv
// Registered 1-to-2 stream demultiplexer with an independent holding slot per output.
// Define DEMUX_XFER_CNT_EN to expose per-output delivered-beat counters cnt0/cnt1.
module stream_demux1to2
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out1_data
`ifdef DEMUX_XFER_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1
`endif
);

  logic space0, space1;
  logic accept, wr0, wr1;

  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end

  // in_ready looks only at the addressed slot; in_valid never feeds it.
  assign in_ready = (in_sel == SEL_OUT1) ? space1 : space0;
  assign accept   = in_valid & in_ready;
  assign wr0      = accept & (in_sel == SEL_OUT0);
  assign wr1      = accept & (in_sel == SEL_OUT1);

  demux_slot #(
    .DataWidth (DATA_WIDTH)
`ifdef DEMUX_XFER_CNT_EN
    ,
    .CntWidth  (CNT_WIDTH)
`endif
  ) u_slot0 (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (wr0),
    .wr_data_i (in_data),
    .valid_o   (out0_valid),
    .ready_i   (out0_ready),
    .data_o    (out0_data),
    .space_o   (space0)
`ifdef DEMUX_XFER_CNT_EN
    ,
    .cnt_o     (cnt0)
`endif
  );

  demux_slot #(
    .DataWidth (DATA_WIDTH)
`ifdef DEMUX_XFER_CNT_EN
    ,
    .CntWidth  (CNT_WIDTH)
`endif
  ) u_slot1 (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (wr1),
    .wr_data_i (in_data),
    .valid_o   (out1_valid),
    .ready_i   (out1_ready),
    .data_o    (out1_data),
    .space_o   (space1)
`ifdef DEMUX_XFER_CNT_EN
    ,
    .cnt_o     (cnt1)
`endif
  );

endmodule

// File: tb/tb_stream_demux1to2.sv
// Self-checking bench for stream_demux1to2: directed vector table, hand sequences, random traffic.
module tb_stream_demux1to2;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sel = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0, out1_ready = 1'b0;
  logic [DW-1:0] out0_data, out1_data;
`ifdef DEMUX_XFER_CNT_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  stream_demux1to2 #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_XFER_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each output is a FIFO of capacity one.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int unsigned   m_cnt0 = 0, m_cnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs after the edge.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] d,
                      input logic r0, input logic r1, output logic got_rdy);
    logic p0, p1, exp_rdy;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    p0      = (q0.size() != 0) && r0;
    p1      = (q1.size() != 0) && r1;
    exp_rdy = s ? ((q1.size() == 0) || p1) : ((q0.size() == 0) || p0);
    got_rdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clock);
    if (p0) begin
      void'(q0.pop_front());
      m_cnt0 = (m_cnt0 + 1) % (1 << CW);
    end
    if (p1) begin
      void'(q1.pop_front());
      m_cnt1 = (m_cnt1 + 1) % (1 << CW);
    end
    if (v && exp_rdy) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    #1;
    check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) check("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() != 0) check("out1_data", 32'(out1_data), 32'(q1[0]));
`ifdef DEMUX_XFER_CNT_EN
    check("cnt0", 32'(cnt0), m_cnt0);
    check("cnt1", 32'(cnt1), m_cnt1);
`endif
  endtask

  task automatic check_reset_state();
    check("rst_out0_valid", 32'(out0_valid), 32'd0);
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_out0_data", 32'(out0_data), 32'd0);
    check("rst_out1_data", 32'(out1_data), 32'd0);
`ifdef DEMUX_XFER_CNT_EN
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
`endif
  endtask

  typedef struct packed {
    logic          v;
    logic          s;
    logic [DW-1:0] d;
    logic          r0;
    logic          r1;
    logic          rdy;
    logic          v0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [DW-1:0] d1;
  } vec_t;

  vec_t vecs[14];
  logic rdy;

  initial begin
    // single beat, isolation, reload, both-full
    vecs[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22};
    vecs[4]  = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 8'h66};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'h66};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'h66};

    #2;
    check_reset_state();
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1, rdy);
      check($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(vecs[i].rdy));
      check($sformatf("vec%0d_v0", i), 32'(out0_valid), 32'(vecs[i].v0));
      check($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(vecs[i].v1));
      if (vecs[i].v0) check($sformatf("vec%0d_d0", i), 32'(out0_data), 32'(vecs[i].d0));
      if (vecs[i].v1) check($sformatf("vec%0d_d1", i), 32'(out1_data), 32'(vecs[i].d1));
    end

    // Mid-operation reset with both slots full: valids must drop without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_reset_state();
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, rdy);
    check("post_rst_v1", 32'(out1_valid), 32'd1);
    check("post_rst_d1", 32'(out1_data), 32'h5A);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, rdy);

    // Back-to-back stream to out1 at one beat per cycle.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, rdy);
      check("stream_rdy", 32'(rdy), 32'd1);
      check("stream_d1", 32'(out1_data), 32'(i));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, rdy);

    // 17 pops on out0 wraps a 4-bit counter to 1.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, rdy);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, rdy);
`ifdef DEMUX_XFER_CNT_EN
    check("cnt0_wrap", 32'(cnt0), 32'd1);
`endif

    // Random traffic obeying the hold-until-accepted source rule.
    begin
      logic rv, rs, acc;
      logic [DW-1:0] rd;
      rv  = 1'b0;
      rs  = 1'b0;
      rd  = '0;
      acc = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        if (!rv || acc) begin
          rv = 1'($urandom_range(0, 3) != 0);
          rs = 1'($urandom_range(0, 1));
          rd = 8'($urandom_range(0, 255));
        end
        step(rv, rs, rd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), rdy);
        acc = rv && rdy;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
